// File: rtl/low_freq_generator_bcd.sv
// low_freq_generator_bcd
// Turns a 4-digit BCD frequency with a one-hot decimal point into a periodic
// pulse train. The period in clocks is computed once per request with a
// sequential restoring divider (one quotient bit per cycle). A free-running
// period counter then generates the output until i_stop is asserted.
//
// Build option: define LOW_FREQ_GEN_SQUARE_WAVE_EN to replace the one-clock
// pulse with a ~50% duty square wave. The rising-edge spacing and all
// handshakes are unchanged.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; o_ready high
// CONV  | validate latched digits and load the rounded dividend
// DIV   | restoring division, CNT_W cycles, quotient -> o_period
// RUN   | period counter free-runs, o_signal generated from its value

module low_freq_generator_bcd #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned CNT_W    = 37
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [3:0]       i_freq_bcd3,
  input  logic [3:0]       i_freq_bcd2,
  input  logic [3:0]       i_freq_bcd1,
  input  logic [3:0]       i_freq_bcd0,
  input  logic [3:0]       i_freq_dp,
  output logic             o_signal,
  output logic [CNT_W-1:0] o_period,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_err
);

  localparam int DC_W = $clog2(CNT_W);

  // Clock frequency scaled by 10^k, one constant per decimal-point position.
  localparam logic [CNT_W-1:0] FREQ_X1    = CNT_W'(64'(CLK_FREQ));
  localparam logic [CNT_W-1:0] FREQ_X10   = CNT_W'(64'(CLK_FREQ) * 64'd10);
  localparam logic [CNT_W-1:0] FREQ_X100  = CNT_W'(64'(CLK_FREQ) * 64'd100);
  localparam logic [CNT_W-1:0] FREQ_X1000 = CNT_W'(64'(CLK_FREQ) * 64'd1000);

  typedef enum logic [1:0] {IDLE, CONV, DIV, RUN} state_t;

  state_t state, state_next;

  logic [3:0]       d3, d2, d1, d0, dp;
  logic [13:0]      n_val;
  logic             req_ok;
  logic [CNT_W-1:0] scale;
  logic [CNT_W-1:0] dividend;

  logic [13:0]      rem;
  logic [CNT_W-1:0] quo;
  logic [DC_W-1:0]  div_cnt;
  logic [14:0]      r_shift;
  logic [14:0]      r_sub;
  logic             q_bit;
  logic [13:0]      rem_step;
  logic [CNT_W-1:0] quo_step;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] period_next;
  logic             sig_next;
  logic             sig_on;

  // Request decode: integer frequency word, validity and rounded dividend.
  always_comb begin
    n_val = 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
    scale = FREQ_X1;
    req_ok = (d3 <= 4'd9) && (d2 <= 4'd9) && (d1 <= 4'd9) && (d0 <= 4'd9) && (n_val != 14'd0);
    case (dp)
      4'b1000: scale = FREQ_X1000;
      4'b0100: scale = FREQ_X100;
      4'b0010: scale = FREQ_X10;
      4'b0001: scale = FREQ_X1;
      default: req_ok = 1'b0;
    endcase
    // Adding N/2 before the divide rounds the period half-up.
    dividend = scale + CNT_W'(n_val >> 1);
  end

  // One restoring-division step; the remainder always stays below N.
  always_comb begin
    r_shift  = {rem, quo[CNT_W-1]};
    r_sub    = r_shift - {1'b0, n_val};
    q_bit    = (r_shift >= {1'b0, n_val});
    rem_step = q_bit ? r_sub[13:0] : r_shift[13:0];
    quo_step = {quo[CNT_W-2:0], q_bit};
  end

  // Next-state, rejection pulse and period-counter advance.
  always_comb begin
    state_next  = state;
    o_err       = 1'b0;
    cnt_next    = '0;
    period_next = o_period;
    case (state)
      IDLE: begin
        if (i_start && !i_stop) state_next = CONV;
      end
      CONV: begin
        if (i_stop) begin
          state_next = IDLE;
        end else if (!req_ok) begin
          state_next = IDLE;
          o_err      = 1'b1;
        end else begin
          state_next = DIV;
        end
      end
      DIV: begin
        if (i_stop) begin
          state_next = IDLE;
        end else if (div_cnt == '0) begin
          state_next  = RUN;
          period_next = quo_step;
        end
      end
      RUN: begin
        if (i_stop) state_next = IDLE;
        else if (cnt != o_period - CNT_W'(1)) cnt_next = cnt + CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
`ifdef LOW_FREQ_GEN_SQUARE_WAVE_EN
    sig_on = (cnt_next < (period_next - (period_next >> 1)));
`else
    sig_on = (cnt_next == '0);
`endif
    sig_next = (state_next == RUN) && sig_on;
    o_ready  = (state == IDLE);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Capture the request so later input changes have no effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d3 <= '0; d2 <= '0; d1 <= '0; d0 <= '0; dp <= '0;
    end else if (state == IDLE && i_start && !i_stop) begin
      d3 <= i_freq_bcd3; d2 <= i_freq_bcd2; d1 <= i_freq_bcd1; d0 <= i_freq_bcd0;
      dp <= i_freq_dp;
    end
  end

  // Divider datapath: load in CONV, shift one bit per DIV cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem     <= '0;
      quo     <= '0;
      div_cnt <= '0;
    end else if (state == CONV && state_next == DIV) begin
      rem     <= '0;
      quo     <= dividend;
      div_cnt <= DC_W'(CNT_W - 1);
    end else if (state == DIV) begin
      rem     <= rem_step;
      quo     <= quo_step;
      div_cnt <= div_cnt - DC_W'(1);
    end
  end

  // Period counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      o_signal <= 1'b0;
      o_done   <= 1'b0;
      o_period <= '0;
    end else begin
      cnt      <= cnt_next;
      o_signal <= sig_next;
      o_done   <= (state == DIV) && (state_next == RUN);
      o_period <= period_next;
    end
  end

endmodule

// File: tb/tb_low_freq_generator_bcd.sv
// Directed bench for low_freq_generator_bcd at CLK_FREQ = 100 MHz.
// Long periods are checked through o_period only, to keep run time short.
module tb_low_freq_generator_bcd;

  localparam int unsigned CNT_W = 37;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [3:0]       bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0, dp = '0;
  logic             sig;
  logic [CNT_W-1:0] period;
  logic             ready, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  low_freq_generator_bcd #(.CLK_FREQ(100_000_000), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_freq_bcd3(bcd3), .i_freq_bcd2(bcd2), .i_freq_bcd1(bcd1), .i_freq_bcd0(bcd0),
    .i_freq_dp(dp), .o_signal(sig), .o_period(period), .o_ready(ready),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [3:0] a3, a2, a1, a0, input logic [3:0] p);
    bcd3 = a3; bcd2 = a2; bcd1 = a1; bcd0 = a0; dp = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rise(input int bound, output int n);
    logic prev;
    prev = sig;
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (sig && !prev) break;
      prev = sig;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (ready !== 1'b1 || sig !== 1'b0 || done !== 1'b0 || err !== 1'b0 || period !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b sig=%b done=%b err=%b period=%0d, need 1 0 0 0 0",
               ready, sig, done, err, period);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_gen_9999();
    int n;
    start_req(4'd9, 4'd9, 4'd9, 4'd9, 4'b0001);
    wait_done(n);
    n_cmp++;
    if (n !== 38) begin n_bad++; $display("FAIL latency_9999: got %0d, need 38", n); end
    n_cmp++;
    if (period !== 37'd10001) begin n_bad++; $display("FAIL period_9999: got %0d, need 10001", period); end
    n_cmp++;
    if (sig !== 1'b1) begin n_bad++; $display("FAIL first_edge_9999: sig=%b, need 1", sig); end
    for (int i = 0; i < 2; i++) begin
      wait_rise(20000, n);
      n_cmp++;
      if (n !== 10001) begin n_bad++; $display("FAIL spacing_9999[%0d]: got %0d, need 10001", i, n); end
    end
    do_stop();
  endtask

  task automatic test_gen_1000();
    int n, total;
    start_req(4'd1, 4'd0, 4'd0, 4'd0, 4'b0001);
    // Changing inputs and re-pulsing start mid-flight must not disturb the request.
    bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9; dp = 4'b1000;
    total = 0;
    for (int i = 0; i < 5; i++) begin tick(); total++; end
    start = 1'b1; tick(); total++; start = 1'b0;
    wait_done(n);
    total += n;
    n_cmp++;
    if (total !== 38) begin n_bad++; $display("FAIL latency_1000: got %0d, need 38", total); end
    n_cmp++;
    if (period !== 37'd100000) begin n_bad++; $display("FAIL period_1000: got %0d, need 100000", period); end
    n_cmp++;
    if (sig !== 1'b1) begin n_bad++; $display("FAIL first_edge_1000: sig=%b, need 1", sig); end
    do_stop();
  endtask

  task automatic test_gen_1234();
    int n;
    start_req(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
    wait_done(n);
    n_cmp++;
    if (n !== 38 || period !== 37'd8103728) begin
      n_bad++;
      $display("FAIL period_12_34: latency %0d period %0d, need 38 8103728", n, period);
    end
    do_stop();
  endtask

  task automatic test_gen_extremes();
    int n;
    // 9.999 Hz: largest dividend the width must hold.
    start_req(4'd9, 4'd9, 4'd9, 4'd9, 4'b1000);
    wait_done(n);
    n_cmp++;
    if (period !== 37'd10001000) begin n_bad++; $display("FAIL period_9_999: got %0d, need 10001000", period); end
    do_stop();
    // 000.5 Hz
    start_req(4'd0, 4'd0, 4'd0, 4'd5, 4'b0010);
    wait_done(n);
    n_cmp++;
    if (period !== 37'd200000000) begin n_bad++; $display("FAIL period_0_5: got %0d, need 200000000", period); end
    do_stop();
    // 6 Hz: 16666666.67 rounds up.
    start_req(4'd0, 4'd0, 4'd0, 4'd6, 4'b0001);
    wait_done(n);
    n_cmp++;
    if (period !== 37'd16666667) begin n_bad++; $display("FAIL period_round_6: got %0d, need 16666667", period); end
    do_stop();
  endtask

  task automatic test_reject();
    logic [3:0] t3 [3], t0 [3], tp [3];
    t3[0] = 4'hA; t0[0] = 4'd1; tp[0] = 4'b0001;
    t3[1] = 4'd1; t0[1] = 4'd4; tp[1] = 4'b0110;
    t3[2] = 4'd0; t0[2] = 4'd0; tp[2] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      start_req(t3[i], 4'd0, 4'd0, t0[i], tp[i]);
      n_cmp++;
      if (err !== 1'b1 || ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_pulse[%0d]: err=%b ready=%b, need 1 0", i, err, ready);
      end
      tick();
      n_cmp++;
      if (err !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || period !== 37'd16666667) begin
        n_bad++;
        $display("FAIL reject_after[%0d]: err=%b ready=%b done=%b period=%0d, need 0 1 0 16666667",
                 i, err, ready, done, period);
      end
    end
  endtask

  task automatic test_start_stop_same();
    bcd3 = 4'd1; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0; dp = 4'b0001;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL start_stop_same: ready=%b err=%b, need 1 0", ready, err);
    end
  endtask

  task automatic test_stop_restart();
    int n;
    start_req(4'd9, 4'd9, 4'd9, 4'd9, 4'b0001);
    wait_done(n);
    for (int i = 0; i < 100; i++) tick();
    do_stop();
    n_cmp++;
    if (sig !== 1'b0 || ready !== 1'b1 || period !== 37'd10001) begin
      n_bad++;
      $display("FAIL stop_run: sig=%b ready=%b period=%0d, need 0 1 10001", sig, ready, period);
    end
    start_req(4'd9, 4'd9, 4'd9, 4'd9, 4'b0001);
    wait_done(n);
    n_cmp++;
    if (n !== 38 || period !== 37'd10001) begin
      n_bad++;
      $display("FAIL restart: latency %0d period %0d, need 38 10001", n, period);
    end
    wait_rise(20000, n);
    n_cmp++;
    if (n !== 10001) begin n_bad++; $display("FAIL restart_spacing: got %0d, need 10001", n); end
    do_stop();
  endtask

  task automatic test_reset_in_div();
    int n;
    start_req(4'd1, 4'd0, 4'd0, 4'd0, 4'b0001);
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || sig !== 1'b0 || done !== 1'b0 || err !== 1'b0 || period !== '0) begin
      n_bad++;
      $display("FAIL reset_in_div: ready=%b sig=%b done=%b err=%b period=%0d, need 1 0 0 0 0",
               ready, sig, done, err, period);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_req(4'd0, 4'd0, 4'd0, 4'd6, 4'b0001);
    wait_done(n);
    n_cmp++;
    if (n !== 38 || period !== 37'd16666667) begin
      n_bad++;
      $display("FAIL after_reset: latency %0d period %0d, need 38 16666667", n, period);
    end
  endtask

  initial begin
    test_reset();
    test_gen_9999();
    test_gen_1000();
    test_gen_1234();
    test_gen_extremes();
    test_reject();
    test_start_stop_same();
    test_stop_restart();
    test_reset_in_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
